uart_parity_unit: RTL and testbench

- Parametrised parity unit for the UART datapath: generates the Tx parity bit from a parallel word and checks Rx parity by accumulating serial bits as they are sampled.
- Supports even, odd, mark and space parity, and a runtime data length of 1..DATA_WIDTH bits.
- Sits between the Tx/Rx FSMs and the serialiser/sampler.
- Supersedes the fixed 8-bit even/odd generator.

---
 rtl/uart_parity_unit.sv | 122 ++++++++++++
 tb/tb_uart_parity_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_unit.sv
// UART parity unit: registered Tx parity generation from a parallel word, and
// an Rx parity check that accumulates sampled serial bits frame by frame.
module uart_parity_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            par_type,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  parity_result,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  par_valid,
  input  logic                  par_in,
  output logic                  busy,
  output logic                  chk_done,
  output logic                  par_err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WAIT_PAR
  } state_t;

  state_t           state;
  logic             acc;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_l;
  logic [1:0]       mode_l;
  logic [LEN_W-1:0] cnt_nxt;

  // Out-of-range lengths (including 0) fall back to the full word.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > MAX_LEN) return MAX_LEN;
    return len;
  endfunction

  function automatic logic masked_xor(input logic [DATA_WIDTH-1:0] d,
                                      input logic [LEN_W-1:0]      len);
    logic x;
    x = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(len)) x ^= d[i];
    end
    return x;
  endfunction

  function automatic logic apply_mode(input logic x, input logic [1:0] mode);
    case (mode)
      2'd0:    return x;
      2'd1:    return ~x;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign cnt_nxt = cnt + LEN_W'(1);

  // Tx generation: one-cycle latency, independent of the check FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_result <= 1'b0;
    end else if (load) begin
      parity_result <= apply_mode(masked_xor(data_in, eff_len(data_len)), par_type);
    end
  end

  // Rx check FSM: abort beats start, start beats any in-frame strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acc      <= 1'b0;
      cnt      <= '0;
      len_l    <= '0;
      mode_l   <= 2'd0;
      busy     <= 1'b0;
      chk_done <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      chk_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (start) begin
        acc    <= 1'b0;
        cnt    <= '0;
        mode_l <= par_type;
        len_l  <= eff_len(data_len);
        state  <= ACCUM;
        busy   <= 1'b1;
      end else begin
        case (state)
          ACCUM: begin
            if (bit_valid) begin
              acc <= acc ^ bit_in;
              cnt <= cnt_nxt;
              if (cnt_nxt == len_l) state <= WAIT_PAR;
            end
          end
          WAIT_PAR: begin
            if (par_valid) begin
              par_err  <= (par_in != apply_mode(acc, mode_l));
              chk_done <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_parity_unit.sv
// Bench for uart_parity_unit: generation vector table plus hand-written Rx
// check sequences scored through expected-result queues.
module tb_uart_parity_unit;
  localparam int DW = 8;
  localparam int LW = $clog2(DW + 1);

  logic          clk;
  logic          rst;
  logic [1:0]    par_type;
  logic [LW-1:0] data_len;
  logic          load;
  logic [DW-1:0] data_in;
  logic          parity_result;
  logic          start;
  logic          abort;
  logic          bit_valid;
  logic          bit_in;
  logic          par_valid;
  logic          par_in;
  logic          busy;
  logic          chk_done;
  logic          par_err;

  uart_parity_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .par_type(par_type), .data_len(data_len),
    .load(load), .data_in(data_in), .parity_result(parity_result),
    .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
    .par_valid(par_valid), .par_in(par_in), .busy(busy),
    .chk_done(chk_done), .par_err(par_err)
  );

  typedef struct {
    logic [1:0]    pt;
    logic [LW-1:0] len;
    logic [DW-1:0] d;
    logic          exp;
  } gen_vec_t;

  gen_vec_t vecs[10];
  logic     gen_q[$];
  logic     err_q[$];
  int       checks = 0;
  int       errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  // Scoreboard side: every chk_done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst && chk_done) begin
      if (err_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_chk_done actual=1 required=0");
      end else begin
        check1("par_err", par_err, err_q.pop_front());
        check1("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in    = w[i];
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = ~w[i];
      if (i % 2 == 0) @(negedge clk);
    end
  endtask

  task automatic begin_frame(input logic [1:0] pt, input logic [LW-1:0] len);
    par_type = pt;
    data_len = len;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    par_type = ~pt;
    data_len = LW'(3);
    check1("busy_start", busy, 1'b1);
  endtask

  task automatic send_par(input logic pin, input logic exp_err);
    err_q.push_back(exp_err);
    par_valid = 1'b1;
    par_in    = pin;
    @(negedge clk);
    par_valid = 1'b0;
    par_in    = ~pin;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10; i++) begin
      if (err_q.size() == 0) break;
      @(negedge clk);
    end
    if (err_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL chk_done_timeout actual=pending%0d required=0", err_q.size());
      err_q.delete();
    end
  endtask

  task automatic run_frame(input logic [1:0] pt, input logic [LW-1:0] len,
                           input logic [15:0] w, input int n,
                           input logic pin, input logic exp_err);
    begin_frame(pt, len);
    send_bits(w, n);
    check1("busy_wait_par", busy, 1'b1);
    send_par(pin, exp_err);
    wait_done();
  endtask

  initial begin
    vecs[0] = '{2'd0, LW'(8),  8'hA5, 1'b0};
    vecs[1] = '{2'd1, LW'(8),  8'hA5, 1'b1};
    vecs[2] = '{2'd0, LW'(8),  8'h07, 1'b1};
    vecs[3] = '{2'd0, LW'(5),  8'hE1, 1'b1};
    vecs[4] = '{2'd0, LW'(0),  8'hE1, 1'b0};
    vecs[5] = '{2'd2, LW'(3),  8'h00, 1'b1};
    vecs[6] = '{2'd3, LW'(8),  8'hFF, 1'b0};
    vecs[7] = '{2'd1, LW'(1),  8'hFE, 1'b1};
    vecs[8] = '{2'd0, LW'(15), 8'h01, 1'b1};
    vecs[9] = '{2'd1, LW'(7),  8'h80, 1'b1};

    rst = 1'b1; par_type = 2'd0; data_len = LW'(8); load = 1'b0; data_in = '0;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    par_valid = 1'b0; par_in = 1'b0;
    #2 rst = 1'b0;
    #2;
    check1("rst_parity_result", parity_result, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_chk_done", chk_done, 1'b0);
    check1("rst_par_err", par_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Generation table
    for (int i = 0; i < 10; i++) begin
      par_type = vecs[i].pt;
      data_len = vecs[i].len;
      data_in  = vecs[i].d;
      load     = 1'b1;
      gen_q.push_back(vecs[i].exp);
      @(negedge clk);
      load = 1'b0;
      check1($sformatf("gen%0d", i), parity_result, gen_q.pop_front());
    end
    data_in  = 8'h00;
    par_type = 2'd0;
    repeat (2) begin
      @(negedge clk);
      check1("gen_hold", parity_result, 1'b1);
    end

    // Check frames: odd pass, odd fail, space, mark
    run_frame(2'd1, LW'(8), 16'h003C, 8, 1'b1, 1'b0);
    run_frame(2'd1, LW'(8), 16'h003C, 8, 1'b0, 1'b1);
    run_frame(2'd3, LW'(7), 16'h002A, 7, 1'b0, 1'b0);
    run_frame(2'd2, LW'(7), 16'h0055, 7, 1'b0, 1'b1);

    // Abort after 3 bits, with start in the same cycle
    begin_frame(2'd0, LW'(8));
    send_bits(16'h0007, 3);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check1("abort_busy", busy, 1'b0);
    check1("abort_par_err", par_err, 1'b1);
    check1("abort_chk_done", chk_done, 1'b0);
    par_valid = 1'b1;
    par_in    = 1'b0;
    @(negedge clk);
    par_valid = 1'b0;
    @(negedge clk);
    check1("idle_par_valid_busy", busy, 1'b0);

    // Restart after 4 bits; strobes in the restart cycle are ignored
    begin_frame(2'd1, LW'(8));
    send_bits(16'h0001, 4);
    par_type  = 2'd0;
    data_len  = LW'(8);
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    par_valid = 1'b1;
    par_in    = 1'b1;
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b0; par_valid = 1'b0; par_type = 2'd1;
    check1("restart_busy", busy, 1'b1);
    send_bits(16'h00A5, 7);
    par_valid = 1'b1;
    par_in    = 1'b1;
    @(negedge clk);
    par_valid = 1'b0;
    @(negedge clk);
    check1("accum_ignores_par", busy, 1'b1);
    send_bits(16'h0001, 1);
    check1("restart_wait_par", busy, 1'b1);
    send_par(1'b0, 1'b0);
    wait_done();

    // Short frame with latched length 5
    run_frame(2'd0, LW'(5), 16'h0013, 5, 1'b0, 1'b1);

    // Reset while waiting for the parity bit
    par_type = 2'd2;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check1("pre_reset_gen", parity_result, 1'b1);
    begin_frame(2'd1, LW'(8));
    send_bits(16'h003C, 8);
    check1("pre_reset_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check1("mid_rst_parity_result", parity_result, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_chk_done", chk_done, 1'b0);
    check1("mid_rst_par_err", par_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(2'd0, LW'(8), 16'h003C, 8, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
